// File: rtl/polyphase_interp_ctrl.sv
// Sequencer for a multi-channel polyphase FIR upsampler: loads one NCH-channel
// input frame, then walks L phases x NCH channels of TAPS-tap dot products.
module polyphase_interp_ctrl #(
  parameter int L       = 4,
  parameter int TAPS    = 8,
  parameter int NCH     = 2,
  parameter int MAC_LAT = 2,
  parameter int DA_W    = $clog2(NCH * TAPS),
  parameter int CA_W    = $clog2(L * TAPS),
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PH_W   = $clog2(L)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  input  logic            sat_i,
  output logic [DA_W-1:0] data_addr_o,
  output logic [CA_W-1:0] coef_addr_o,
  output logic [CH_W-1:0] ch_o,
  output logic [PH_W-1:0] phase_o,
  output logic            mac_init_o,
  output logic            mac_en_o,
  output logic            res_latch_o,
  output logic            res_err_o,
  output logic [7:0]      err_cnt_o,
  output logic [2:0]      state_o
);

  localparam int TW   = $clog2(TAPS);
  localparam int DC_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [CH_W-1:0] C_LAST = CH_W'(NCH - 1);
  localparam logic [PH_W-1:0] P_LAST = PH_W'(L - 1);
  localparam logic [TW-1:0]   K_LAST = TW'(TAPS - 1);
  localparam logic [DC_W-1:0] D_LAST = DC_W'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
    S_CALC  = 3'd3,
    S_DRAIN = 3'd4,
    S_RES   = 3'd5,
    S_OUT   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   wp_q, wp_d;
  logic [TW-1:0]   k_q, k_d;
  logic [CH_W-1:0] c_q, c_d;
  logic [PH_W-1:0] p_q, p_d;
  logic [DC_W-1:0] dcnt_q, dcnt_d;
  logic            res_err_q, res_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [TW-1:0]        tap;
  logic [CH_W+TW-1:0]   da_full;
  logic [PH_W+TW-1:0]   ca_full;

  // Tap k reads the sample written k frames ago; the TW-bit subtraction wraps the ring.
  assign tap     = wp_q - k_q;
  assign da_full = {c_q, tap};
  assign ca_full = {p_q, k_q};

  assign data_addr_o = da_full[DA_W-1:0];
  assign coef_addr_o = ca_full[CA_W-1:0];
  assign ch_o        = c_q;
  assign phase_o     = p_q;
  assign in_ready_o  = en_i && (state_q == S_LOAD);
  assign out_valid_o = (state_q == S_OUT);
  assign mac_init_o  = (state_q == S_INIT);
  assign mac_en_o    = (state_q == S_INIT) || (state_q == S_CALC);
  assign res_latch_o = (state_q == S_RES);
  assign res_err_o   = res_err_q;
  assign err_cnt_o   = err_cnt_q;
  assign state_o     = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      k_q       <= '0;
      c_q       <= '0;
      p_q       <= '0;
      dcnt_q    <= '0;
      res_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      k_q       <= k_d;
      c_q       <= c_d;
      p_q       <= p_d;
      dcnt_q    <= dcnt_d;
      res_err_q <= res_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // With en low nothing advances, so every output derived from state holds.
  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    k_d       = k_q;
    c_d       = c_q;
    p_d       = p_q;
    dcnt_d    = dcnt_q;
    res_err_d = res_err_q;
    err_cnt_d = err_cnt_q;
    if (en_i) begin
      case (state_q)
        S_IDLE: state_d = S_LOAD;
        S_LOAD: begin
          if (in_valid_i) begin
            if (c_q == C_LAST) begin
              c_d     = '0;
              p_d     = '0;
              k_d     = '0;
              state_d = S_INIT;
            end else begin
              c_d = c_q + 1'b1;
            end
          end
        end
        S_INIT: begin
          k_d     = TW'(1);
          state_d = S_CALC;
        end
        S_CALC: begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            dcnt_d  = '0;
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (dcnt_q == D_LAST) begin
            dcnt_d  = '0;
            state_d = S_RES;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        S_RES: begin
          res_err_d = sat_i;
          if (sat_i && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
          state_d = S_OUT;
        end
        S_OUT: begin
          if (out_ready_i) begin
            state_d = S_INIT;
            if (c_q == C_LAST) begin
              c_d = '0;
              if (p_q == P_LAST) begin
                p_d     = '0;
                wp_d    = wp_q + 1'b1;
                state_d = S_LOAD;
              end else begin
                p_d = p_q + 1'b1;
              end
            end else begin
              c_d = c_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polyphase_interp_ctrl.sv
// Directed bench for polyphase_interp_ctrl: a result table for the first two
// frames, then pointer-wrap, error-counter saturation and mid-frame reset sequences.
module tb_polyphase_interp_ctrl;

  localparam int L       = 4;
  localparam int TAPS    = 8;
  localparam int NCH     = 2;
  localparam int MAC_LAT = 2;

  logic       clk = 1'b0;
  logic       rstN;
  logic       en;
  logic       inValid;
  logic       inReady;
  logic       outValid;
  logic       outReady;
  logic       sat;
  logic [3:0] dataAddr;
  logic [4:0] coefAddr;
  logic [0:0] ch;
  logic [1:0] phase;
  logic       macInit;
  logic       macEn;
  logic       resLatch;
  logic       resErr;
  logic [7:0] errCnt;
  logic [2:0] state;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    int wp;
    int phase;
    int ch;
    int satIn;
    int expErr;
    int expErrCnt;
    int stall;
    int enGap;
  } vec_t;

  vec_t vecs [16];
  int   sweepRef [8] = '{10, 9, 8, 15, 14, 13, 12, 11};

  always #5 clk = ~clk;

  polyphase_interp_ctrl #(
    .L(L), .TAPS(TAPS), .NCH(NCH), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .en_i(en),
    .in_valid_i(inValid),
    .in_ready_o(inReady),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .sat_i(sat),
    .data_addr_o(dataAddr),
    .coef_addr_o(coefAddr),
    .ch_o(ch),
    .phase_o(phase),
    .mac_init_o(macInit),
    .mac_en_o(macEn),
    .res_latch_o(resLatch),
    .res_err_o(resErr),
    .err_cnt_o(errCnt),
    .state_o(state)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".state"},    state,    0);
    checkOutput({tag, ".inReady"},  inReady,  0);
    checkOutput({tag, ".outValid"}, outValid, 0);
    checkOutput({tag, ".dataAddr"}, dataAddr, 0);
    checkOutput({tag, ".coefAddr"}, coefAddr, 0);
    checkOutput({tag, ".ch"},       ch,       0);
    checkOutput({tag, ".phase"},    phase,    0);
    checkOutput({tag, ".macInit"},  macInit,  0);
    checkOutput({tag, ".macEn"},    macEn,    0);
    checkOutput({tag, ".resLatch"}, resLatch, 0);
    checkOutput({tag, ".resErr"},   resErr,   0);
    checkOutput({tag, ".errCnt"},   errCnt,   0);
  endtask

  task automatic waitLoadAfterRelease();
    bit seen = 0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      if (inReady) seen = 1;
    end
    checkOutput("inReadyAfterRelease", seen, 1);
  endtask

  // Feeds one NCH-sample frame and checks the write addresses c*TAPS+wp.
  task automatic applyStimulus(input int wpExp);
    inValid = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      int waited = 0;
      while (!inReady && waited < 20) begin
        tick();
        waited++;
      end
      if (!inReady) begin
        checkOutput("inReadyTimeout", inReady, 1);
        break;
      end
      checkOutput("loadAddr", dataAddr, c * TAPS + wpExp);
      tick();
    end
    inValid = 1'b0;
  endtask

  task automatic checkTap(input int wpExp, input int ph, input int c, input int k);
    checkOutput("tapState",   state,    (k == 0) ? 2 : 3);
    checkOutput("tapCoef",    coefAddr, ph * TAPS + k);
    checkOutput("tapData",    dataAddr, c * TAPS + ((wpExp - k) & (TAPS - 1)));
    checkOutput("tapMacEn",   macEn,    1);
    checkOutput("tapMacInit", macInit,  (k == 0) ? 1 : 0);
  endtask

  // Walks one dot product from INIT through the output handshake.
  task automatic runResult(input int wpExp, input int ph, input int c, input int satIn,
                           input int expErr, input int expErrCnt, input int stall,
                           input int enGap);
    for (int k = 0; k < TAPS; k++) begin
      checkTap(wpExp, ph, c, k);
      if (wpExp == 2 && ph == 1 && c == 1) begin
        checkOutput("sweepData", dataAddr, sweepRef[k]);
        checkOutput("sweepCoef", coefAddr, 8 + k);
      end
      if (k == 3 && enGap > 0) begin
        en = 1'b0;
        for (int g = 0; g < enGap; g++) begin
          tick();
          checkTap(wpExp, ph, c, k);
          checkOutput("gapInReady", inReady, 0);
        end
        en = 1'b1;
      end
      tick();
    end
    for (int d = 0; d < MAC_LAT; d++) begin
      checkOutput("drainState", state, 4);
      checkOutput("drainMacEn", macEn, 0);
      tick();
    end
    checkOutput("resState", state, 5);
    checkOutput("resLatch", resLatch, 1);
    sat = satIn[0];
    tick();
    sat = 1'b0;
    checkOutput("outValid",  outValid, 1);
    checkOutput("outCh",     ch,       c);
    checkOutput("outPhase",  phase,    ph);
    checkOutput("outResErr", resErr,   expErr);
    checkOutput("outErrCnt", errCnt,   expErrCnt);
    if (stall > 0) begin
      outReady = 1'b0;
      for (int s = 0; s < stall; s++) begin
        tick();
        checkOutput("stallValid",   outValid, 1);
        checkOutput("stallCh",      ch,       c);
        checkOutput("stallPhase",   phase,    ph);
        checkOutput("stallMacInit", macInit,  0);
      end
      outReady = 1'b1;
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wpM;
    int cnt;

    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 1, 1, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 0, 1, 0, 0};
    vecs[4]  = '{0, 2, 0, 0, 0, 1, 5, 0};
    vecs[5]  = '{0, 2, 1, 1, 1, 2, 0, 0};
    vecs[6]  = '{0, 3, 0, 0, 0, 2, 0, 0};
    vecs[7]  = '{0, 3, 1, 0, 0, 2, 0, 4};
    vecs[8]  = '{1, 0, 0, 0, 0, 2, 0, 0};
    vecs[9]  = '{1, 0, 1, 0, 0, 2, 0, 0};
    vecs[10] = '{1, 1, 0, 0, 0, 2, 0, 0};
    vecs[11] = '{1, 1, 1, 1, 1, 3, 0, 0};
    vecs[12] = '{1, 2, 0, 0, 0, 3, 0, 0};
    vecs[13] = '{1, 2, 1, 0, 0, 3, 0, 4};
    vecs[14] = '{1, 3, 0, 0, 0, 3, 3, 0};
    vecs[15] = '{1, 3, 1, 0, 0, 3, 0, 0};

    rstN     = 1'b0;
    en       = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    sat      = 1'b0;
    repeat (3) tick();
    checkReset("reset");

    rstN = 1'b1;
    en   = 1'b1;
    waitLoadAfterRelease();

    for (int i = 0; i < 16; i++) begin
      if (i % (L * NCH) == 0) applyStimulus(vecs[i].wp);
      runResult(vecs[i].wp, vecs[i].phase, vecs[i].ch, vecs[i].satIn,
                vecs[i].expErr, vecs[i].expErrCnt, vecs[i].stall, vecs[i].enGap);
    end

    // Frames 3..9: address sweep on frame 3, ring wrap back to wp=0 on frame 9.
    for (int f = 2; f <= 8; f++) begin
      wpM = f % TAPS;
      applyStimulus(wpM);
      for (int r = 0; r < L * NCH; r++) runResult(wpM, r / NCH, r % NCH, 0, 0, 3, 0, 0);
    end

    cnt = 3;
    for (int f = 0; f < 38; f++) begin
      wpM = (9 + f) % TAPS;
      applyStimulus(wpM);
      for (int r = 0; r < L * NCH; r++) begin
        cnt = (cnt < 255) ? cnt + 1 : 255;
        runResult(wpM, r / NCH, r % NCH, 1, 1, cnt, 0, 0);
      end
    end
    checkOutput("errCntSaturated", errCnt, 255);

    wpM = (9 + 38) % TAPS;
    applyStimulus(wpM);
    repeat (3) tick();
    checkOutput("preResetState", state, 3);
    rstN = 1'b0;
    #1;
    checkReset("midCalcReset");
    tick();
    checkReset("resetHeld");
    rstN = 1'b1;
    waitLoadAfterRelease();
    applyStimulus(0);
    runResult(0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule
